// File: rtl/if_stage.sv
// RISC-V fetch stage: PC register, next-PC select and IF/ID pipeline register; optional IF_REDIRECT_CNT_EN redirect counter.
// Latency: the instruction fetched at PCF=X appears on InstrD one cycle later.
// Backpressure: StallF holds the PC and StallD holds IF/ID; a redirect overrides StallF and a flush overrides StallD.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [15:0] RedirectCnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  logic [31:0] pc_q;
  logic [31:0] pc_plus4f;
  logic [31:0] pc_nxt;
  ifid_t       ifid_q;
  ifid_t       ifid_nxt;

  assign pc_plus4f = pc_q + 32'd4;

  // Redirect beats a fetch stall; target alignment bits are dropped silently.
  always_comb begin
    pc_nxt = pc_plus4f;
    if (PCSrcE)      pc_nxt = {PCTargetE[31:2], 2'b00};
    else if (StallF) pc_nxt = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_nxt;
  end

  always_comb begin
    ifid_nxt = ifid_q;
    if (FlushD) begin
      ifid_nxt = BUBBLE;
    end else if (!StallD) begin
      ifid_nxt.instr    = InstrF;
      ifid_nxt.pc       = pc_q;
      ifid_nxt.pc_plus4 = pc_plus4f;
      ifid_nxt.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid_q <= BUBBLE;
    else        ifid_q <= ifid_nxt;
  end

  assign PCF      = pc_q;
  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

`ifdef IF_REDIRECT_CNT_EN
  logic [15:0] redirect_q;

  // Saturating so a long-running count never aliases back to small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                redirect_q <= 16'h0000;
    else if (PCSrcE && redirect_q != 16'hFFFF) redirect_q <= redirect_q + 16'd1;
  end

  assign RedirectCnt = redirect_q;
`else
  assign RedirectCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed bench for if_stage against a rule-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [15:0] RedirectCnt;

  int checks = 0;
  int fails  = 0;

  // Model state: what the rules say the stage should hold.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4d;
  logic        m_vd;
  logic [15:0] m_cnt;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCF(PCF), .InstrF(InstrF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RedirectCnt(RedirectCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  always_comb InstrF = memf(PCF);

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_p4d = 32'h0; m_vd = 1'b0; m_cnt = 16'h0;
  endtask

  // Drive one cycle of inputs from a negedge, advance the model, return at the next negedge.
  task automatic step(input logic sf, input logic sd, input logic fd, input logic ps,
                      input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    if (fd) begin
      m_instr = NOP; m_pcd = 32'h0; m_p4d = 32'h0; m_vd = 1'b0;
    end else if (!sd) begin
      m_instr = memf(m_pc); m_pcd = m_pc; m_p4d = m_pc + 32'd4; m_vd = 1'b1;
    end
`ifdef IF_REDIRECT_CNT_EN
    if (ps && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    if (ps)       m_pc = tgt & 32'hFFFF_FFFC;
    else if (!sf) m_pc = m_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (PCF !== 32'h0) begin fails++; $display("FAIL reset_pcf: got %h expected %h", PCF, 32'h0); end
    checks++; if (InstrD !== NOP) begin fails++; $display("FAIL reset_instrd: got %h expected %h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin fails++; $display("FAIL reset_pcd: got %h/%h expected 0/0", PCD, PCPlus4D); end
    checks++; if (ValidD !== 1'b0) begin fails++; $display("FAIL reset_validd: got %b expected 0", ValidD); end
    checks++; if (RedirectCnt !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h expected 0", RedirectCnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 32'h0);
      checks++; if (PCF !== 32'd4 * i) begin fails++; $display("FAIL seq_pcf%0d: got %h expected %h", i, PCF, 32'd4 * i); end
      checks++; if (InstrD !== memf(32'd4 * (i - 1))) begin fails++; $display("FAIL seq_instrd%0d: got %h expected %h", i, InstrD, memf(32'd4 * (i - 1))); end
      checks++; if (ValidD !== 1'b1) begin fails++; $display("FAIL seq_validd%0d: got %b expected 1", i, ValidD); end
      checks++; if (PCPlus4D !== PCD + 32'd4 || PCD !== 32'd4 * (i - 1)) begin fails++; $display("FAIL seq_pcd%0d: got %h/%h expected %h/%h", i, PCD, PCPlus4D, 32'd4 * (i - 1), 32'd4 * i); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 32'h0);
      checks++; if (PCF !== 32'h10) begin fails++; $display("FAIL stall_pcf%0d: got %h expected 00000010", i, PCF); end
      checks++; if (PCD !== 32'hC || InstrD !== memf(32'hC)) begin fails++; $display("FAIL stall_ifid%0d: got %h/%h expected 0000000c/%h", i, PCD, InstrD, memf(32'hC)); end
    end
    step(0, 0, 0, 0, 32'h0);
    checks++; if (PCF !== 32'h14) begin fails++; $display("FAIL stall_resume_pcf: got %h expected 00000014", PCF); end
    checks++; if (InstrD !== memf(32'h10) || PCD !== 32'h10) begin fails++; $display("FAIL stall_resume_instrd: got %h/%h expected %h/00000010", InstrD, PCD, memf(32'h10)); end
  endtask

  task automatic test_redirect();
    step(0, 0, 1, 1, 32'h103);
    checks++; if (PCF !== 32'h100) begin fails++; $display("FAIL redir_pcf: got %h expected 00000100", PCF); end
    checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin fails++; $display("FAIL redir_bubble: got %h/%b expected %h/0", InstrD, ValidD, NOP); end
    step(0, 0, 0, 0, 32'h0);
    checks++; if (InstrD !== memf(32'h100) || PCD !== 32'h100 || ValidD !== 1'b1) begin fails++; $display("FAIL redir_next: got %h/%h/%b expected %h/00000100/1", InstrD, PCD, ValidD, memf(32'h100)); end
  endtask

  task automatic test_redirect_over_stall();
    step(1, 1, 1, 1, 32'h202);
    checks++; if (PCF !== 32'h200) begin fails++; $display("FAIL prio_pcf: got %h expected 00000200", PCF); end
    checks++; if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin fails++; $display("FAIL prio_bubble: got %h/%h/%h/%b expected bubble", InstrD, PCD, PCPlus4D, ValidD); end
    step(1, 1, 0, 0, 32'h0);
    checks++; if (PCF !== 32'h200 || ValidD !== 1'b0 || InstrD !== NOP) begin fails++; $display("FAIL prio_hold: got %h/%b/%h expected 00000200/0/%h", PCF, ValidD, InstrD, NOP); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 1, 32'hFFFF_FFFF);
    checks++; if (PCF !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pcf_top: got %h expected fffffffc", PCF); end
    step(0, 0, 0, 0, 32'h0);
    checks++; if (PCF !== 32'h0) begin fails++; $display("FAIL wrap_pcf: got %h expected 00000000", PCF); end
    checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin fails++; $display("FAIL wrap_pcplus4d: got %h/%h expected fffffffc/00000000", PCD, PCPlus4D); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom);
      checks++; if (PCF !== m_pc) begin fails++; $display("FAIL rand_pcf%0d: got %h expected %h", i, PCF, m_pc); end
      checks++; if (InstrD !== m_instr) begin fails++; $display("FAIL rand_instrd%0d: got %h expected %h", i, InstrD, m_instr); end
      checks++; if (PCD !== m_pcd || PCPlus4D !== m_p4d) begin fails++; $display("FAIL rand_pcd%0d: got %h/%h expected %h/%h", i, PCD, PCPlus4D, m_pcd, m_p4d); end
      checks++; if (ValidD !== m_vd) begin fails++; $display("FAIL rand_validd%0d: got %b expected %b", i, ValidD, m_vd); end
      checks++; if (RedirectCnt !== m_cnt) begin fails++; $display("FAIL rand_cnt%0d: got %h expected %h", i, RedirectCnt, m_cnt); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0 || RedirectCnt !== 16'h0)
      begin fails++; $display("FAIL async_reset: got %h/%h/%h/%h/%b/%h expected reset values", PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectCnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 32'h0);
    checks++; if (PCF !== 32'h4 || InstrD !== memf(32'h0) || ValidD !== 1'b1) begin fails++; $display("FAIL async_restart: got %h/%h/%b expected 00000004/%h/1", PCF, InstrD, ValidD, memf(32'h0)); end
  endtask

  task automatic test_counter();
`ifdef IF_REDIRECT_CNT_EN
    force dut.redirect_q = 16'hFFFE;
    #1 release dut.redirect_q;
    m_cnt = 16'hFFFE;
    step(0, 0, 1, 1, 32'h40);
    checks++; if (RedirectCnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_reach: got %h expected ffff", RedirectCnt); end
    step(0, 0, 1, 1, 32'h80);
    checks++; if (RedirectCnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_saturate: got %h expected ffff", RedirectCnt); end
`else
    step(0, 0, 1, 1, 32'h40);
    step(0, 0, 1, 1, 32'h80);
    checks++; if (RedirectCnt !== 16'h0) begin fails++; $display("FAIL cnt_tied: got %h expected 0000", RedirectCnt); end
`endif
    checks++; if (PCF !== 32'h80) begin fails++; $display("FAIL cnt_pcf: got %h expected 00000080", PCF); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_wrap();
    test_random();
    test_async_reset();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
